dac_ctl: RTL and testbench

DAC_CTL -- requirements
Module: dac_ctl

---
 rtl/dac_ctl_if.sv | 22 ++
 rtl/dac_ctl.sv | 127 ++++++++++++
 tb/tb_dac_ctl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ctl_if.sv
// rtl/dac_ctl_if.sv - request handshake and SPI pins of the DAC write controller
interface dac_ctl_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] din;
    logic              dvalid;
    logic              busy;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_sdi;
    logic              spi_ldac_n;

    modport master (
        output din, dvalid,
        input  busy, spi_cs_n, spi_sck, spi_sdi, spi_ldac_n
    );

    modport slave (
        input  din, dvalid,
        output busy, spi_cs_n, spi_sck, spi_sdi, spi_ldac_n
    );
endinterface

// File: rtl/dac_ctl.sv
// rtl/dac_ctl.sv - single-word SPI mode-0 writer for a 16-bit-frame DAC with LDAC latch pulse
module dac_ctl #(
    parameter int DATA_W   = 10,
    parameter int SCK_HALF = 2
) (
    input  logic     clk,
    input  logic     rst,
    dac_ctl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_LDAC  = 3'd5;

    // Phase counter must also reach 1 for the two-cycle GAP and LDAC states.
    localparam int             PH_W    = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCK_HALF - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    logic [2:0]      state;
    logic [PH_W-1:0] ph;
    logic [3:0]      bit_cnt;
    logic [15:0]     shreg;
    logic            cs_n_r;
    logic            sck_r;
    logic            sdi_r;
    logic            ldac_n_r;
    logic            busy_r;
    logic [15:0]     cmd_word;

    // Write command, unbuffered, 1x gain, active; code left-justified in 12 bits.
    assign cmd_word = {4'b0011, 12'(bus.din) << (12 - DATA_W)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ph       <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cs_n_r   <= 1'b1;
            sck_r    <= 1'b0;
            sdi_r    <= 1'b0;
            ldac_n_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.dvalid) begin
                        // shreg holds the bits still to be sent after the one on sdi
                        shreg  <= {cmd_word[14:0], 1'b0};
                        sdi_r  <= cmd_word[15];
                        cs_n_r <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ph      <= '0;
                    bit_cnt <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ph == PH_LAST) begin
                        ph <= '0;
                        if (!sck_r) begin
                            sck_r <= 1'b1;
                        end else begin
                            // sdi only moves together with the falling sck edge
                            sck_r <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                sdi_r <= 1'b0;
                                state <= S_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sdi_r   <= shreg[15];
                                shreg   <= {shreg[14:0], 1'b0};
                            end
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_HOLD: begin
                    cs_n_r <= 1'b1;
                    ph     <= '0;
                    state  <= S_GAP;
                end
                S_GAP: begin
                    if (ph == PH_ONE) begin
                        ph       <= '0;
                        ldac_n_r <= 1'b0;
                        state    <= S_LDAC;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                S_LDAC: begin
                    if (ph == PH_ONE) begin
                        ph       <= '0;
                        ldac_n_r <= 1'b1;
                        busy_r   <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ph       <= '0;
                    cs_n_r   <= 1'b1;
                    sck_r    <= 1'b0;
                    sdi_r    <= 1'b0;
                    ldac_n_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spi_cs_n   = cs_n_r;
    assign bus.spi_sck    = sck_r;
    assign bus.spi_sdi    = sdi_r;
    assign bus.spi_ldac_n = ldac_n_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_dac_ctl.sv
// tb/tb_dac_ctl.sv - directed scoreboard bench for dac_ctl with an SPI/DAC receiver model
`timescale 1ns/1ps
module tb_dac_ctl;
    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 tb_clk = ~tb_clk;

    dac_ctl_if #(.DATA_W(10)) bus ();

    dac_ctl #(.DATA_W(10), .SCK_HALF(2)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] exp_words [$];
    logic [15:0] rx_words  [$];
    int          rx_edges  [$];
    int          rx_cslen  [$];
    int          rx_gap    [$];
    int          rx_ldac   [$];
    int          rx_busy   [$];

    // Receiver model: samples on the falling tb_clk edge, away from DUT updates.
    logic        prev_sck  = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_ldac = 1'b1;
    logic [15:0] sh        = '0;
    logic [15:0] last_word = '0;
    logic [9:0]  dac_out   = '0;
    bit          in_frame  = 1'b0;
    bit          in_gap    = 1'b0;
    int          bits = 0, cs_len = 0, gap_run = 0, ldac_run = 0, busy_run = 0;
    int          overlap_err = 0, stray_edges = 0;

    always @(negedge tb_clk) begin
        if (bus.spi_cs_n === 1'b0 && bus.spi_ldac_n === 1'b0) overlap_err++;
        if (rst) begin
            in_frame = 1'b0;
            in_gap   = 1'b0;
            busy_run = 0;
            ldac_run = 0;
        end else begin
            if (prev_cs && !bus.spi_cs_n) begin
                in_frame = 1'b1;
                bits     = 0;
                sh       = '0;
                cs_len   = 0;
            end
            if (!bus.spi_cs_n && in_frame) begin
                cs_len++;
                if (bus.spi_sck && !prev_sck) begin
                    sh = {sh[14:0], bus.spi_sdi};
                    bits++;
                end
            end else if (bus.spi_sck && !prev_sck) begin
                stray_edges++;
            end
            if (!prev_cs && bus.spi_cs_n && in_frame) begin
                in_frame  = 1'b0;
                rx_words.push_back(sh);
                rx_edges.push_back(bits);
                rx_cslen.push_back(cs_len);
                last_word = sh;
                in_gap    = 1'b1;
                gap_run   = 1;
            end else if (in_gap && bus.spi_ldac_n) begin
                gap_run++;
            end
            if (!bus.spi_ldac_n) begin
                if (in_gap) begin
                    rx_gap.push_back(gap_run);
                    in_gap  = 1'b0;
                    dac_out = last_word[11:2];
                end
                ldac_run++;
            end else if (!prev_ldac) begin
                rx_ldac.push_back(ldac_run);
                ldac_run = 0;
            end
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                rx_busy.push_back(busy_run);
                busy_run = 0;
            end
        end
        prev_sck  = bus.spi_sck;
        prev_cs   = bus.spi_cs_n;
        prev_ldac = bus.spi_ldac_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [9:0] v, input bit expect_it);
        @(negedge tb_clk);
        bus.din    = v;
        bus.dvalid = 1'b1;
        if (expect_it) exp_words.push_back({4'b0011, v, 2'b00});
        @(negedge tb_clk);
        bus.dvalid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (rx_busy.size() < n && k < 400) begin
            @(negedge tb_clk);
            k++;
        end
        @(negedge tb_clk);
        check({tag, "_timeout"}, 32'(rx_busy.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] ew;
        bit ok;
        ok = exp_words.size() != 0 && rx_words.size() != 0 && rx_gap.size() != 0
             && rx_ldac.size() != 0 && rx_busy.size() != 0;
        check({tag, "_present"}, 32'(ok), 32'd1);
        if (!ok) return;
        ew = exp_words.pop_front();
        check({tag, "_word"},   32'(rx_words.pop_front()), 32'(ew));
        check({tag, "_edges"},  32'(rx_edges.pop_front()), 32'd16);
        check({tag, "_cs_len"}, 32'(rx_cslen.pop_front()), 32'd66);
        check({tag, "_gap"},    32'(rx_gap.pop_front()),   32'd2);
        check({tag, "_ldac"},   32'(rx_ldac.pop_front()),  32'd2);
        check({tag, "_busy"},   32'(rx_busy.pop_front()),  32'd70);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din    = '0;
        bus.dvalid = 1'b0;

        // reset held three cycles
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge tb_clk);
        check("idle_outputs", 32'({bus.spi_cs_n, bus.spi_sck, bus.spi_sdi, bus.spi_ldac_n, bus.busy}), 32'b10010);

        // first write
        do_write(10'h1AE, 1'b1);
        check("accept_busy", 32'(bus.busy), 32'd1);
        wait_frames(1, "w1ae");
        check_frame("w1ae");
        check("w1ae_dac", 32'(dac_out), 32'h1AE);

        repeat (10) @(negedge tb_clk);
        do_write(10'h305, 1'b1);
        wait_frames(1, "w305");
        check_frame("w305");
        check("w305_dac", 32'(dac_out), 32'h305);

        // request while busy must be dropped
        do_write(10'h000, 1'b1);
        repeat (19) @(negedge tb_clk);
        do_write(10'h3FF, 1'b0);
        wait_frames(1, "ign");
        check_frame("ign");
        repeat (10) @(negedge tb_clk);
        check("ign_no_extra", 32'(rx_words.size()), 32'd0);
        check("ign_idle", 32'(bus.busy), 32'd0);
        check("ign_dac", 32'(dac_out), 32'h000);

        // dvalid on the busy-falling edge is dropped, on the next edge is taken
        do_write(10'h1C3, 1'b1);
        repeat (69) @(negedge tb_clk);
        bus.din    = 10'h155;
        bus.dvalid = 1'b1;
        @(negedge tb_clk);
        check("b2b_busy_fell", 32'(bus.busy), 32'd0);
        bus.din = 10'h2AA;
        exp_words.push_back({4'b0011, 10'h2AA, 2'b00});
        @(negedge tb_clk);
        bus.dvalid = 1'b0;
        check("b2b_restart", 32'(bus.busy), 32'd1);
        wait_frames(2, "b2b");
        check_frame("b2b_a");
        check_frame("b2b_b");
        check("b2b_dac", 32'(dac_out), 32'h2AA);

        // asynchronous abort in the middle of SHIFT
        repeat (5) @(negedge tb_clk);
        do_write(10'h0AA, 1'b0);
        repeat (30) @(negedge tb_clk);
        #2 rst = 1'b1;
        #1;
        check("abort_cs_sck", 32'({bus.spi_cs_n, bus.spi_sck}), 32'b10);
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge tb_clk);
        rst = 1'b0;
        repeat (120) @(negedge tb_clk);
        check("abort_no_frame", 32'(rx_words.size() + rx_ldac.size() + rx_busy.size()), 32'd0);
        check("abort_dac", 32'(dac_out), 32'h2AA);

        // normal operation after reset
        do_write(10'h123, 1'b1);
        wait_frames(1, "post");
        check_frame("post");
        check("post_dac", 32'(dac_out), 32'h123);

        check("cs_ldac_overlap", 32'(overlap_err), 32'd0);
        check("stray_sck", 32'(stray_edges), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
